// File: rtl/bw_calc_pkg.sv
// Shared types and constants for the bandwidth calculator.
package bw_calc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Guard bits above CNT_WIDTH used to detect numerator overflow.
    localparam int unsigned OVF_GUARD = 16;

    // Shift equivalent to multiplying by bytes per beat: log2(data_width/8).
    function automatic int unsigned bpb_shift(input int unsigned data_width);
        int unsigned bytes;
        int unsigned s;
        bytes = data_width / 8;
        s     = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((bytes >> i) == 1) s = i;
        end
        return s;
    endfunction

endpackage

// File: rtl/bw_calc_seq_divider.sv
// Restoring divider, one quotient bit per cycle, MSB first, WIDTH cycles.
// done marks the cycle in which the final step executes; q and r are that
// step's results and are meaningful while done is high.
module seq_divider #(
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             done
);

    localparam int unsigned     CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] den;
    logic [CW-1:0]    cnt;
    logic             active;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   diff;
    logic             take;

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    always_comb begin
        rem_shift = {rem, quo[WIDTH-1]};
        diff      = rem_shift - {1'b0, den};
        take      = (rem_shift >= {1'b0, den});
        r         = take ? diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
        q         = {quo[WIDTH-2:0], take};
        done      = active && (cnt == LAST);
    end

    // Iteration registers; quotient bits replace dividend bits as they shift out.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rem    <= '0;
            quo    <= '0;
            den    <= '0;
            cnt    <= '0;
            active <= 1'b0;
        end else if (start) begin
            rem    <= '0;
            quo    <= n;
            den    <= d;
            cnt    <= '0;
            active <= 1'b1;
        end else if (active) begin
            rem <= r;
            quo <= q;
            cnt <= cnt + CW'(1);
            if (done) active <= 1'b0;
        end
    end

endmodule

// File: rtl/bw_calc.sv
// Bandwidth calculator: MB/s = beats * bytes_per_beat * CLK_MHZ / cycles.
// Optional macro BW_CALC_ROUND_EN rounds the quotient to nearest (+1 cycle).
module bw_calc
    import bw_calc_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 128,
    parameter int unsigned CLK_MHZ    = 100,
    parameter int unsigned CNT_WIDTH  = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 test_done,
    input  logic [CNT_WIDTH-1:0] total_len,
    input  logic [CNT_WIDTH-1:0] time_counter,
    output logic [CNT_WIDTH-1:0] result,
    output logic                 result_valid,
    input  logic                 result_ready,
    output logic                 div_by_zero,
    output logic                 overflow,
    output logic                 busy
);

    localparam int unsigned    NW        = CNT_WIDTH + OVF_GUARD;
    localparam int unsigned    BPB_SHIFT = bpb_shift(DATA_WIDTH);
    localparam logic [NW-1:0]  MHZ_EXT   = NW'(CLK_MHZ);

    state_t                state, state_next;
    logic                  done_d;
    logic                  rise;
    logic                  d_zero;
    logic [NW-1:0]         prod;
    logic                  div_start;
    logic [CNT_WIDTH-1:0]  div_q;
    logic                  div_done;
`ifdef BW_CALC_ROUND_EN
    logic [CNT_WIDTH-1:0]  div_r;
    logic [CNT_WIDTH-1:0]  q_raw;
    logic [CNT_WIDTH-1:0]  r_raw;
    logic [CNT_WIDTH-1:0]  den;
    logic                  round_pend;
    logic [CNT_WIDTH-1:0]  rounded;
`else
    logic [CNT_WIDTH-1:0]  unused_rem;
`endif

    // Numerator scaling, edge detect and handshake-facing status.
    always_comb begin
        prod         = ({{OVF_GUARD{1'b0}}, total_len} << BPB_SHIFT) * MHZ_EXT;
        rise         = test_done && !done_d;
        d_zero       = (time_counter == '0);
        div_start    = (state == LOAD) && !d_zero;
        busy         = (state == LOAD) || (state == DIV);
        result_valid = (state == DONE);
    end

    seq_divider #(
        .WIDTH(CNT_WIDTH)
    ) u_div (
        .clk  (clk),
        .rst_n(rst_n),
        .start(div_start),
        .n    (prod[CNT_WIDTH-1:0]),
        .d    (time_counter),
        .q    (div_q),
`ifdef BW_CALC_ROUND_EN
        .r    (div_r),
`else
        .r    (unused_rem),
`endif
        .done (div_done)
    );

`ifdef BW_CALC_ROUND_EN
    // Round half up; remainder < den so doubling it cannot exceed CNT_WIDTH+1 bits.
    always_comb begin
        rounded = q_raw;
        if (({r_raw, 1'b0} >= {1'b0, den}) && (q_raw != '1)) rounded = q_raw + CNT_WIDTH'(1);
    end
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state logic; edges outside IDLE are dropped.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (rise) state_next = LOAD;
            LOAD: state_next = d_zero ? DONE : DIV;
`ifdef BW_CALC_ROUND_EN
            DIV:  if (round_pend) state_next = DONE;
`else
            DIV:  if (div_done) state_next = DONE;
`endif
            DONE: if (result_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Result and flag registers, held from completion until the next LOAD.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            done_d      <= 1'b0;
            result      <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
`ifdef BW_CALC_ROUND_EN
            q_raw       <= '0;
            r_raw       <= '0;
            den         <= '0;
            round_pend  <= 1'b0;
`endif
        end else begin
            done_d <= test_done;
            case (state)
                LOAD: begin
                    overflow    <= |prod[NW-1:CNT_WIDTH];
                    div_by_zero <= d_zero;
                    if (d_zero) result <= '1;
`ifdef BW_CALC_ROUND_EN
                    den <= time_counter;
`endif
                end
                DIV: begin
`ifdef BW_CALC_ROUND_EN
                    // Capture the raw quotient, then round on the following cycle.
                    if (div_done) begin
                        q_raw      <= div_q;
                        r_raw      <= div_r;
                        round_pend <= 1'b1;
                    end
                    if (round_pend) begin
                        result     <= rounded;
                        round_pend <= 1'b0;
                    end
`else
                    if (div_done) result <= div_q;
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bw_calc.sv
// Directed, table-driven bench for bw_calc at default parameters.
module tb_bw_calc;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        test_done;
    logic [63:0] total_len;
    logic [63:0] time_counter;
    logic [63:0] result;
    logic        result_valid;
    logic        result_ready;
    logic        div_by_zero;
    logic        overflow;
    logic        busy;

    int checks   = 0;
    int failures = 0;

`ifdef BW_CALC_ROUND_EN
    localparam int LAT_DIV = 66;
    localparam logic [63:0] Q_1_7 = 64'd229;
`else
    localparam int LAT_DIV = 65;
    localparam logic [63:0] Q_1_7 = 64'd228;
`endif

    typedef struct {
        logic [63:0] total_len;
        logic [63:0] time_counter;
        logic [63:0] exp_result;
        logic        exp_dbz;
        logic        exp_ovf;
        int          exp_lat;
    } vec_t;

    vec_t vecs[7];

    bw_calc #(
        .DATA_WIDTH(128),
        .CLK_MHZ   (100),
        .CNT_WIDTH (64)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .test_done   (test_done),
        .total_len   (total_len),
        .time_counter(time_counter),
        .result      (result),
        .result_valid(result_valid),
        .result_ready(result_ready),
        .div_by_zero (div_by_zero),
        .overflow    (overflow),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Raise test_done, count cycles to result_valid, compare, then handshake.
    task automatic run_vec(input vec_t v, input int idx);
        int lat;
        total_len    = v.total_len;
        time_counter = v.time_counter;
        result_ready = 1'b1;
        test_done    = 1'b1;
        tick();
        lat = 0;
        do begin
            tick();
            lat++;
            if (lat == 1 && v.exp_lat > 1) check($sformatf("busy_load[%0d]", idx), 64'(busy), 64'd1);
        end while (!result_valid && lat < 200);
        check($sformatf("latency[%0d]", idx), 64'(lat), 64'(v.exp_lat));
        check($sformatf("result[%0d]", idx), result, v.exp_result);
        check($sformatf("div_by_zero[%0d]", idx), 64'(div_by_zero), 64'(v.exp_dbz));
        check($sformatf("overflow[%0d]", idx), 64'(overflow), 64'(v.exp_ovf));
        check($sformatf("busy_done[%0d]", idx), 64'(busy), 64'd0);
        test_done = 1'b0;
        tick();
        check($sformatf("valid_clear[%0d]", idx), 64'(result_valid), 64'd0);
    endtask

    initial begin
        int lat;
        vecs[0] = '{64'd1000, 64'd2000, 64'd800, 1'b0, 1'b0, LAT_DIV};
        vecs[1] = '{64'd1, 64'd7, Q_1_7, 1'b0, 1'b0, LAT_DIV};
        vecs[2] = '{64'd1, 64'd3, 64'd533, 1'b0, 1'b0, LAT_DIV};
        vecs[3] = '{64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1};
        vecs[4] = '{64'h1000_0000_0000_0000, 64'd1, 64'd0, 1'b0, 1'b1, LAT_DIV};
        vecs[5] = '{64'd0, 64'd5, 64'd0, 1'b0, 1'b0, LAT_DIV};
        vecs[6] = '{64'd12345, 64'd1000, 64'd19752, 1'b0, 1'b0, LAT_DIV};

        rst_n        = 1'b0;
        test_done    = 1'b0;
        total_len    = '0;
        time_counter = '0;
        result_ready = 1'b1;
        tick();
        tick();
        check("rst_result", result, 64'd0);
        check("rst_valid", 64'(result_valid), 64'd0);
        check("rst_dbz", 64'(div_by_zero), 64'd0);
        check("rst_ovf", 64'(overflow), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

        // Consumer stalls in DONE; a test_done re-pulse there must be ignored.
        total_len    = 64'd1000;
        time_counter = 64'd2000;
        result_ready = 1'b0;
        test_done    = 1'b1;
        tick();
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!result_valid && lat < 200);
        check("stall_latency", 64'(lat), 64'(LAT_DIV));
        for (int i = 0; i < 10; i++) begin
            if (i == 3) test_done = 1'b0;
            if (i == 5) test_done = 1'b1;
            tick();
            check($sformatf("stall_valid[%0d]", i), 64'(result_valid), 64'd1);
            check($sformatf("stall_result[%0d]", i), result, 64'd800);
        end
        result_ready = 1'b1;
        tick();
        check("stall_release", 64'(result_valid), 64'd0);
        repeat (3) tick();
        check("repulse_busy", 64'(busy), 64'd0);
        check("repulse_valid", 64'(result_valid), 64'd0);
        test_done = 1'b0;
        tick();

        // Reset pulse during DIV iteration 30 aborts the division.
        time_counter = 64'd7;
        test_done    = 1'b1;
        tick();
        repeat (31) tick();
        check("mid_div_busy", 64'(busy), 64'd1);
        rst_n     = 1'b0;
        test_done = 1'b0;
        tick();
        check("abort_result", result, 64'd0);
        check("abort_valid", 64'(result_valid), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_dbz", 64'(div_by_zero), 64'd0);
        check("abort_ovf", 64'(overflow), 64'd0);
        rst_n = 1'b1;
        repeat (70) tick();
        check("abort_idle_valid", 64'(result_valid), 64'd0);
        run_vec(vecs[0], 100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
